perf_event_monitor: RTL
=======================

Name: perf_event_monitor

Overview:
Synthesizable, parametrised successor to the bench-side instruction and cache-event counters. It counts NUM_CH single-bit processor events in hardware, for example RegWrite|MemWrite|Halt, ICacheReq, ICacheHit, DCacheReq and DCacheHit. It also counts run cycles and freezes all counts when Halt is observed. It sits beside the pipeline at the processor top level and offers a registered select/readout port, so counts survive into hardware runs where no simulator log exists.

Parameters:
NUM_CH, 8, number of event channels (1..16)
CNT_W, 32, width of each event counter and of the cycle counter (4..32)
SAT_MODE, 0, 0 = counters wrap at 2^CNT_W, 1 = counters saturate at 2^CNT_W-1
SEL_W, 4, width of rd_sel; must satisfy 2^SEL_W >= NUM_CH+1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin counting (IDLE->RUN)
halt  in  1  processor Halt (memory stage); freezes counts
clear  in  1  zero all counters and overflow flags
evt  in  NUM_CH  per-channel event pulses, one count per cycle asserted
rd_sel  in  SEL_W  0..NUM_CH-1 selects an event channel; NUM_CH selects the cycle counter
rd_data  out  CNT_W  registered count of the selected source
rd_ovf  out  1  registered sticky overflow flag of the selected source
state  out  2  00 IDLE, 01 RUN, 10 HALTED
ovf_any  out  1  OR of all sticky overflow flags

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is named clk and the reset port is named rst.
- Reset: state=IDLE. All counters, overflow flags, rd_data, rd_ovf and ovf_any are 0.
- FSM:
  - IDLE -> RUN when start=1.
  - RUN -> HALTED when halt=1.
  - HALTED -> IDLE when clear=1.
  - start is ignored in RUN and HALTED; halt is ignored in IDLE and HALTED.
  - Encoding 11 is unreachable and recovers to IDLE.
- Counting: only in cycles where the current state is RUN. Each channel i increments by 1 when evt[i]=1. The cycle counter increments every RUN cycle.
- The cycle in which halt is sampled in RUN is still counted, for both events and cycles. No counting occurs from the next cycle on.
- The start cycle itself is not counted, because state is still IDLE in that cycle.
- Arithmetic is unsigned, CNT_W bits.
  - Wrap mode: max+1 -> 0 and the sticky ovf bit is set.
  - Saturate mode: the count holds at max and the sticky ovf bit is set on an attempted increment at max.
  - Once set, ovf stays 1 until clear or rst.
- clear: zeroes every counter and ovf flag at the clock edge in any state. It has priority over a same-cycle increment, so the result is 0, not 1.
  - clear in HALTED also moves the FSM to IDLE.
  - clear in IDLE or RUN leaves the state unchanged.
  - clear with start in IDLE: counters are 0 and state becomes RUN.
- Readout:
  - rd_data and rd_ovf are registered with 1-cycle latency from rd_sel. They show the counter value after the previous edge's update.
  - rd_sel > NUM_CH returns rd_data=0 and rd_ovf=0.
  - Readout operates in all states, including during counting.
- rst asserted mid-RUN: all state is discarded the next edge and the block behaves as after power-up reset.
- ovf_any is registered and updates on the same edge as the flags.

Decomposition:
- Package perf_mon_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_HALTED;
  - the cycle-counter select index function, which returns NUM_CH.
- Sub-module perf_cnt_cell is one CNT_W counter with en, clr, SAT_MODE and a sticky ovf.
  - It is instantiated NUM_CH+1 times via generate.
  - The top level holds the FSM, the cell enables and the registered readout mux.

Test Plan:
- Reset, then start; drive evt[0]=1 for 5 RUN cycles, with all other channels at 0. Then rd_sel=0 -> rd_data=5 one cycle later; rd_sel=NUM_CH -> cycle count equals RUN cycles elapsed; rd_sel=1 -> 0.
- In RUN, assert halt with evt[2]=1 in the same cycle, then keep evt[2]=1 for 10 more cycles -> channel 2 counts exactly 1 and state=10. A later start is ignored.
- CNT_W=4, SAT_MODE=0: 17 events on ch3 -> rd_data=1, rd_ovf=1, ovf_any=1. CNT_W=4, SAT_MODE=1: 17 events -> rd_data=15, rd_ovf=1.
- Assert clear with evt[1]=1 while in RUN -> ch1 reads 0 the next cycle and counts 1 the cycle after; state stays RUN. Assert clear in HALTED -> state=IDLE and all counts are 0.
- Assert rst mid-RUN with nonzero counts -> next cycle state=IDLE, rd_data=0, ovf_any=0. Start again -> counting resumes from 0.
- Set rd_sel=NUM_CH+1 -> rd_data=0 and rd_ovf=0. Change rd_sel each cycle -> rd_data tracks it with exactly 1-cycle lag.

Source files
------------

// File: rtl/perf_mon_pkg.sv
// Shared constants and helpers for the performance event monitor.
package perf_mon_pkg;

  // Monitor FSM encoding; 2'b11 is unused and recovers to idle.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  // The cycle counter sits directly after the event channels in the readout map.
  function automatic int unsigned cycleSel(input int unsigned numCh);
    return numCh;
  endfunction

endpackage

// File: rtl/perf_cnt_cell.sv
// One event counter with synchronous clear, wrap or saturate arithmetic and a sticky overflow.
module perf_cnt_cell #(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             ovfNext
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] countNext;

  // Next count/flag: clear beats increment; an increment at max sets the sticky flag.
  always_comb begin
    countNext = count;
    ovfNext   = ovf;
    if (clr) begin
      countNext = '0;
      ovfNext   = 1'b0;
    end else if (en) begin
      if (count == CntMax) begin
        ovfNext   = 1'b1;
        countNext = SAT_MODE ? CntMax : '0;
      end else begin
        countNext = count + 1'b1;
      end
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= countNext;
      ovf   <= ovfNext;
    end
  end

endmodule

// File: rtl/perf_event_monitor.sv
// Counts per-channel processor events and run cycles between start and halt, with a
// registered select/readout port and a global sticky overflow indication.
module perf_event_monitor
  import perf_mon_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned CNT_W    = 32,
  parameter bit          SAT_MODE = 1'b0,
  parameter int unsigned SEL_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              clear,
  input  logic [NUM_CH-1:0] evt,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic [1:0]        state,
  output logic              ovf_any
);

  localparam int unsigned NumSrc = NUM_CH + 1;
  localparam int unsigned CycSel = cycleSel(NUM_CH);

  logic [1:0]        stateQ, stateD;
  logic              runNow;
  logic [NumSrc-1:0] cellEn, cellOvf, cellOvfNext;
  logic [CNT_W-1:0]  cellCnt [NumSrc];
  logic [CNT_W-1:0]  rdDataD, rdDataQ;
  logic              rdOvfD, rdOvfQ, ovfAnyQ;

  assign runNow  = (stateQ == ST_RUN);
  assign state   = stateQ;
  assign rd_data = rdDataQ;
  assign rd_ovf  = rdOvfQ;
  assign ovf_any = ovfAnyQ;

  // FSM next state; start only matters in idle, halt only in run.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_IDLE:   if (start) stateD = ST_RUN;
      ST_RUN:    if (halt)  stateD = ST_HALTED;
      ST_HALTED: if (clear) stateD = ST_IDLE;
      default:   stateD = ST_IDLE;
    endcase
  end

  // Cell enables: the current cycle counts only when the present state is run.
  always_comb begin
    cellEn = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cellEn[i] = runNow & evt[i];
    end
    cellEn[CycSel] = runNow;
  end

  for (genvar g = 0; g < int'(NumSrc); g++) begin : gCell
    perf_cnt_cell #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) uCell (
      .clk     (clk),
      .rst     (rst),
      .en      (cellEn[g]),
      .clr     (clear),
      .count   (cellCnt[g]),
      .ovf     (cellOvf[g]),
      .ovfNext (cellOvfNext[g])
    );
  end

  // Readout mux over current counter values; out-of-range selects read as zero.
  always_comb begin
    rdDataD = '0;
    rdOvfD  = 1'b0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rdDataD = cellCnt[i];
        rdOvfD  = cellOvf[i];
      end
    end
  end

  // State, readout and ovf_any registers; ovf_any follows the flags' next values so it
  // changes on the same edge as the flags themselves.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= ST_IDLE;
      rdDataQ <= '0;
      rdOvfQ  <= 1'b0;
      ovfAnyQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      rdDataQ <= rdDataD;
      rdOvfQ  <= rdOvfD;
      ovfAnyQ <= |cellOvfNext;
    end
  end

endmodule
